// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus an MMIO window holding a cycle counter and a debug output FIFO.
// Define DMEM_CYCLE_COUNTER_EN to build the CYCLE register; otherwise its address reads as unmapped.
module dmem_mmio #(
    parameter int RAM_AW     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] ADDR_CYCLE   = 32'hF000_0000;
    localparam logic [31:0] ADDR_OUTDATA = 32'hF000_0004;
    localparam logic [31:0] ADDR_STATUS  = 32'hF000_0008;

    // ---------------- address decode ----------------
    logic              sel_ram;
    logic              sel_cycle;
    logic              sel_outdata;
    logic              sel_status;
    logic [RAM_AW-1:0] ram_idx;

    assign sel_ram     = (a[31:28] == 4'h0);
    assign sel_cycle   = (a == ADDR_CYCLE);
    assign sel_outdata = (a == ADDR_OUTDATA);
    assign sel_status  = (a == ADDR_STATUS);
    assign ram_idx     = a[RAM_AW+1:2];

    // ---------------- RAM (async read, sync write, never reset) ----------------
    logic [31:0] ram_mem [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            ram_mem[ram_idx] <= wd;
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cycle_val;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_reg <= '0;
        end else if (we && sel_cycle) begin
            cycle_reg <= wd;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    assign cycle_val = cycle_reg;
`else
    assign cycle_val = '0;
`endif

    // ---------------- output FIFO ----------------
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ovf_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_clear;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign pop        = out_valid && out_ready;
    assign push_req   = we && sel_outdata;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_clear  = we && sel_status && wd[2];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (ovf_clear) begin
                ovf_reg <= 1'b0;
            end else if (push_req && !push) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Head is gated so stale storage never shows once the FIFO is empty or reset.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_reg];

    // ---------------- status and read mux ----------------
    logic [3:0]  count_disp;
    logic [31:0] status_val;

    always_comb begin
        count_disp = 4'(count_reg);
        if (32'(count_reg) > 32'd15) begin
            count_disp = 4'd15;
        end
    end

    assign status_val = {24'd0, count_disp, 1'b0, ovf_reg, fifo_full, fifo_empty};

    always_comb begin
        rd = '0;
        if (sel_ram) begin
            rd = ram_mem[ram_idx];
        end else if (sel_cycle) begin
            rd = cycle_val;
        end else if (sel_outdata) begin
            rd = out_data;
        end else if (sel_status) begin
            rd = status_val;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized self-checking bench for dmem_mmio against a queue/array reference model.
module tb_dmem_mmio;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam logic [31:0] A_CYC  = 32'hF000_0000;
    localparam logic [31:0] A_OUT  = 32'hF000_0004;
    localparam logic [31:0] A_STAT = 32'hF000_0008;
`ifdef DMEM_CYCLE_COUNTER_EN
    localparam bit HAS_CYC = 1'b1;
`else
    localparam bit HAS_CYC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] a = 32'h2000_0000;
    logic [31:0] wd = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] rd;
    logic        out_valid;
    logic [31:0] out_data;

    dmem_mmio #(.RAM_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // reference model state
    bit [31:0] m_cyc = 32'd0;
    bit [31:0] m_q[$];
    bit        m_ovf = 1'b0;
    bit [31:0] m_ram [2**AW];
    bit        m_known [2**AW];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
        end
    endtask

    // model update on each rising edge
    always @(posedge clk) begin
        int n;
        bit popped;
        if (!reset) begin
            m_cyc = 32'd0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            n = m_q.size();
            popped = (n > 0) && out_ready;
            if (we && a[31:28] == 4'h0) begin
                m_ram[a[AW+1:2]] = wd;
                m_known[a[AW+1:2]] = 1'b1;
            end
            if (HAS_CYC && we && a == A_CYC) m_cyc = wd;
            else m_cyc = m_cyc + 32'd1;
            if (popped) void'(m_q.pop_front());
            if (we && a == A_OUT) begin
                if (n < DEPTH || popped) m_q.push_back(wd);
                else m_ovf = 1'b1;
            end
            if (we && a == A_STAT && wd[2]) m_ovf = 1'b0;
        end
    end

    // compare process: outputs against model every cycle
    always @(negedge clk) begin
        int n;
        bit [31:0] cyc_v, head, st, e;
        bit ovf_v, known;
        if (cmp_en) begin
            n     = reset ? m_q.size() : 0;
            cyc_v = (reset && HAS_CYC) ? m_cyc : 32'd0;
            ovf_v = reset ? m_ovf : 1'b0;
            head  = (n > 0) ? m_q[0] : 32'd0;
            st    = {24'd0, (n > 15 ? 4'd15 : 4'(n)), 1'b0, ovf_v, (n == DEPTH), (n == 0)};
            known = 1'b1;
            e     = 32'd0;
            if (a[31:28] == 4'h0) begin
                e = m_ram[a[AW+1:2]];
                known = m_known[a[AW+1:2]];
            end else if (a == A_CYC) begin
                e = cyc_v;
            end else if (a == A_OUT) begin
                e = head;
                known = (n > 0);
            end else if (a == A_STAT) begin
                e = st;
            end
            if (known) chk($sformatf("rd@%08h", a), rd, e);
            chk("out_valid", 32'(out_valid), 32'(n > 0));
            if (n > 0) chk("out_data", out_data, head);
            if (!reset) chk("out_data_in_reset", out_data, 32'd0);
        end
    end

    task automatic apply(input bit w, input logic [31:0] ad, input logic [31:0] d, input bit r);
        we = w; a = ad; wd = d; out_ready = r;
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit w, input logic [31:0] ad, input logic [31:0] d, input bit r);
        apply(w, ad, d, r);
        fin();
    endtask

    task automatic peek(input logic [31:0] ad, input logic [31:0] exp, input string name);
        apply(1'b0, ad, 32'd0, 1'b0);
        chk(name, rd, exp);
        fin();
    endtask

    task automatic drain_one(input logic [31:0] exp, input string name);
        apply(1'b0, 32'h2000_0000, 32'd0, 1'b1);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk(name, out_data, exp);
        fin();
    endtask

    initial begin
        logic [31:0] r32, addr, d;
        int k, rdy_pct;
        bit w;

        #2 reset = 1'b0;
        fin();
        cmp_en = 1'b1;

        // reset state
        apply(1'b0, A_STAT, 32'd0, 1'b0);
        chk("rst_status", rd, 32'h0000_0001);
        chk("rst_valid", 32'(out_valid), 32'd0);
        fin();
        peek(A_CYC, 32'd0, "rst_cycle");
        reset = 1'b1;
        peek(A_STAT, 32'h0000_0001, "status_after_rst");
        repeat (4) cyc(1'b0, 32'h2000_0000, 32'd0, 1'b0);
        peek(A_CYC, HAS_CYC ? 32'd5 : 32'd0, "cycle_after_5");

        // RAM store/load, same-cycle old data, aliasing, unmapped write ignored
        cyc(1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
        apply(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        chk("ram_same_cycle_old", rd, 32'h1111_1111);
        fin();
        peek(32'h0000_0010, 32'hDEAD_BEEF, "ram_load");
        peek(32'h0000_0013, 32'hDEAD_BEEF, "ram_byte_offset");
        peek(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias_hi");
        peek(32'h0800_0010, 32'hDEAD_BEEF, "ram_alias_top");
        cyc(1'b1, 32'h1000_0010, 32'h5555_5555, 1'b0);
        peek(32'h0000_0010, 32'hDEAD_BEEF, "unmapped_write_ignored");
        peek(32'h1000_0010, 32'd0, "unmapped_read");

        // FIFO ordering
        for (int i = 1; i <= 3; i++) cyc(1'b1, A_OUT, 32'(i), 1'b0);
        peek(A_STAT, 32'h0000_0030, "status_3");
        peek(A_OUT, 32'd1, "outdata_head");
        for (int i = 1; i <= 3; i++) drain_one(32'(i), "drain_order");
        apply(1'b0, A_STAT, 32'd0, 1'b0);
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_status", rd, 32'h0000_0001);
        fin();

        // overflow and clear
        for (int i = 0; i < 5; i++) cyc(1'b1, A_OUT, 32'h10 + 32'(i), 1'b0);
        peek(A_STAT, 32'h0000_0046, "status_ovf");
        peek(A_OUT, 32'h10, "ovf_head");
        cyc(1'b1, A_STAT, 32'd4, 1'b0);
        peek(A_STAT, 32'h0000_0042, "status_ovf_cleared");

        // full with simultaneous push and pop
        apply(1'b1, A_OUT, 32'd9, 1'b1);
        chk("full_pushpop_head", out_data, 32'h10);
        fin();
        peek(A_STAT, 32'h0000_0042, "status_full_pushpop");
        drain_one(32'h11, "drain_full");
        drain_one(32'h12, "drain_full");
        drain_one(32'h13, "drain_full");
        drain_one(32'd9, "drain_full_last");

        // counter load and wrap
        cyc(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
        peek(A_CYC, HAS_CYC ? 32'hFFFF_FFFE : 32'd0, "cycle_load");
        peek(A_CYC, HAS_CYC ? 32'hFFFF_FFFF : 32'd0, "cycle_max");
        peek(A_CYC, 32'd0, "cycle_wrap");

        // reset asserted mid-push
        cyc(1'b1, A_OUT, 32'hA1, 1'b0);
        cyc(1'b1, A_OUT, 32'hA2, 1'b0);
        reset = 1'b0;
        apply(1'b1, A_OUT, 32'hA3, 1'b0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", out_data, 32'd0);
        fin();
        cyc(1'b0, A_CYC, 32'd0, 1'b0);
        reset = 1'b1;
        apply(1'b0, A_CYC, 32'd0, 1'b0);
        chk("postrst_cycle", rd, 32'd0);
        chk("postrst_valid", 32'(out_valid), 32'd0);
        fin();
        peek(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_reset");

        // randomized traffic checked by the compare process
        for (int it = 0; it < 3000; it++) begin
            rdy_pct = (it < 1500) ? 10 : 60;
            r32 = $urandom();
            k = $urandom_range(0, 9);
            d = $urandom();
            case (k)
                0, 1, 2, 3: addr = {4'h0, r32[27:0]};
                4:          addr = A_CYC;
                5, 6:       addr = A_OUT;
                7:          addr = A_STAT;
                8:          addr = {4'h3, r32[27:0]};
                default:    addr = 32'hF000_0000 + {28'd0, r32[3:2], 2'b00} + {16'd0, r32[31:30], 14'd0};
            endcase
            if (k == 4 && r32[0]) d = 32'hFFFF_FFF0 + {28'd0, d[3:0]};
            w = ($urandom_range(0, 99) < 50);
            cyc(w, addr, d, ($urandom_range(0, 99) < rdy_pct));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory stage for the single-cycle ARM core. Consumes the datapath's memory request (address = ALU result, store data, write enable) and returns load data in the same cycle. It contains a word-addressed RAM plus a small memory-mapped I/O window: a free-running cycle counter and a debug output FIFO with a valid/ready drain port for the testbench or a UART.

## Interface

Parameters:
- `RAM_AW`, default 6: RAM word-address width; the RAM holds 2^RAM_AW 32-bit words.
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `we`  input  1: store enable (MemWrite).
- `a`  input  32: byte address (ALU result). `a[1:0]` is ignored; all accesses are whole words.
- `wd`  input  32: store data.
- `rd`  output  32: load data, combinational from `a`.
- `out_valid`  output  1: FIFO head valid; equals not-empty.
- `out_data`  output  32: FIFO head word.
- `out_ready`  input  1: consumer accepts the head word.

## Operation

- **Address decode:**
  - `a[31:28]==4'h0`: RAM, indexed by `a[RAM_AW+1:2]`. Higher bits in this region alias.
  - `0xF000_0000`: CYCLE.
  - `0xF000_0004`: OUTDATA.
  - `0xF000_0008`: STATUS.
  - Any other address is unmapped: reads return 0 and writes are ignored.
- **RAM:**
  - Asynchronous read.
  - Synchronous write when `we` is high.
  - Contents are not reset.
- **CYCLE:**
  - 32-bit counter, +1 every clock, wraps `0xFFFF_FFFF` to 0.
  - A write loads `wd`; the write wins over the increment in that cycle.
  - Reads return the current value.
- **OUTDATA:**
  - A write pushes `wd` into the FIFO.
  - A read returns the head word without popping.
- **STATUS** read: `{24'b0, count[3:0], 1'b0, ovf, full, empty}`, where count saturates at 15 for display.
  - A write with `wd[2]=1` clears `ovf`.
- **FIFO:**
  - Pop occurs when `out_valid && out_ready`.
  - A push while full and not popping is dropped and sets sticky `ovf`.
  - Push while full with a simultaneous pop: both succeed, and count stays `FIFO_DEPTH`.
  - Push and pop while empty: not possible, since `out_valid` is 0. The push is accepted and count becomes 1.
  - Read and write pointers are `log2(FIFO_DEPTH)` bits and wrap naturally. Count is `log2(FIFO_DEPTH)+1` bits.
- **Reset** (asserted at any time, including mid-push):
  - FIFO empties: `out_valid=0`, `out_data=0`.
  - CYCLE=0 and `ovf=0`.
  - RAM is unchanged.

## Timing

- Load latency is 0 cycles: `rd` settles combinationally from `a` within the same cycle, as the single-cycle datapath requires.
- A store becomes visible to reads in the cycle after the write edge. A same-cycle read of the address being written returns the old data.
- A FIFO push is visible on `out_valid`/`out_data` one cycle after the write edge.
- A pop takes effect at the edge where `out_valid && out_ready` is sampled.
- `out_data` is registered or driven from storage, with no combinational path from `we`/`wd`.
- Reset values:
  - `out_valid=0`, `out_data=0`.
  - `rd` reflects the current address: CYCLE reads 0 and STATUS reads `0x0000_0001` during reset.

## Configuration

- `DMEM_CYCLE_COUNTER_EN` defined: the CYCLE register exists as described.
- Not defined: no counter flops are generated. Reads of `0xF000_0000` return 0 and writes are ignored; the address behaves as unmapped.

## Test plan

- **Reset:** deassert reset, read `0xF000_0008` -> `rd=0x0000_0001`, `out_valid=0`. With the macro, reading `0xF000_0000` after 5 clocks -> 5.
- **RAM store/load:** store `0xDEADBEEF` to `0x0000_0010`; in the same cycle `rd` is old data; next cycle a read of `0x10` -> `0xDEADBEEF`. Reading `0x0000_0013` returns the same word.
- **FIFO ordering:** push 1, 2, 3 with `out_ready=0`; STATUS -> `0x0000_0030`. Assert `out_ready` -> `out_data` sequence 1, 2, 3 on consecutive cycles, then `out_valid=0`.
- **Overflow:**
  - Push 5 words with `FIFO_DEPTH=4` and `out_ready=0` -> STATUS `0x0000_0046`, fifth word lost.
  - Write STATUS with `wd=4` -> `ovf` clears, STATUS `0x0000_0042`.
- **Full with simultaneous push+pop:** FIFO full, `out_ready=1` while pushing 9 -> count stays 4, `ovf` stays 0, 9 appears last.
- **Counter load/wrap and mid-operation reset:**
  - Write CYCLE=`0xFFFF_FFFE` -> reads `0xFFFF_FFFE`, then `0xFFFF_FFFF`, then 0.
  - Pulse reset low mid-stream -> FIFO empty, CYCLE=0, RAM word at `0x10` still `0xDEADBEEF`.
